// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, next-PC selection, link-write generation,
// retired-instruction counter and RUN/HALT/FAULT control for a single-cycle
// MIPS core. Link outputs are combinational; all other outputs are registered.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] pc,
  output logic        link_we,
  output logic [4:0]  link_reg,
  output logic [31:0] link_data,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] retired_r;
  logic        halted_r;
  logic        fault_r;

  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [4:0]  rt_f_s;
  logic [4:0]  rd_s;
  logic [31:0] pc4_s;
  logic [31:0] br_tgt_s;
  logic [31:0] j_tgt_s;
  logic        rs_neg_s;
  logic        rs_zero_s;
  logic [31:0] next_pc_s;
  logic        is_link_s;
  logic        is_break_s;
  logic [4:0]  link_reg_s;
  logic        misaligned_s;
  logic        run_s;

  assign op_s      = instr[31:26];
  assign funct_s   = instr[5:0];
  assign rt_f_s    = instr[20:16];
  assign rd_s      = instr[15:11];
  assign pc4_s     = pc_r + 32'd4;
  assign br_tgt_s  = pc4_s + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign j_tgt_s   = {pc4_s[31:28], instr[25:0], 2'b00};
  assign rs_neg_s  = rs_data[31];
  assign rs_zero_s = (rs_data == 32'd0);

  // Decode the fetched instruction into next PC, link and break indications.
  always_comb begin
    next_pc_s  = pc4_s;
    is_link_s  = 1'b0;
    is_break_s = 1'b0;
    link_reg_s = 5'd31;
    case (op_s)
      6'b000100: if (rs_data == rt_data) next_pc_s = br_tgt_s; else next_pc_s = pc4_s;
      6'b000101: if (rs_data != rt_data) next_pc_s = br_tgt_s; else next_pc_s = pc4_s;
      6'b000110: if (rs_neg_s || rs_zero_s) next_pc_s = br_tgt_s; else next_pc_s = pc4_s;
      6'b000111: if (!rs_neg_s && !rs_zero_s) next_pc_s = br_tgt_s; else next_pc_s = pc4_s;
      6'b000001: begin
        // Bit 0 of the rt field selects >= 0 versus < 0; bit 4 selects the
        // and-link form, which links regardless of the outcome.
        case (rt_f_s)
          5'b00000, 5'b00001, 5'b10000, 5'b10001: begin
            if (rs_neg_s != rt_f_s[0]) next_pc_s = br_tgt_s; else next_pc_s = pc4_s;
            is_link_s = rt_f_s[4];
          end
          default: next_pc_s = pc4_s;
        endcase
      end
      6'b000010: next_pc_s = j_tgt_s;
      6'b000011: begin
        next_pc_s = j_tgt_s;
        is_link_s = 1'b1;
      end
      6'b000000: begin
        case (funct_s)
          6'b001000: next_pc_s = rs_data;
          6'b001001: begin
            next_pc_s  = rs_data;
            is_link_s  = 1'b1;
            link_reg_s = rd_s;
          end
          6'b001101: is_break_s = 1'b1;
          default:   next_pc_s = pc4_s;
        endcase
      end
      default: next_pc_s = pc4_s;
    endcase
  end

  assign misaligned_s = (next_pc_s[1:0] != 2'b00);
  assign run_s        = (state_r == ST_RUN);

  // A misaligned target suppresses the link, so a faulting JALR writes nothing.
  assign link_we   = reset_n & run_s & ~stall & is_link_s & ~is_break_s & ~misaligned_s;
  assign link_reg  = link_reg_s;
  assign link_data = pc4_s;

  // Run-state control, PC update and retire counting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= ST_RUN;
      pc_r      <= RESET_PC;
      retired_r <= 32'd0;
      halted_r  <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (stall) begin
            state_r <= ST_RUN;
          end else if (is_break_s) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else if (misaligned_s) begin
            state_r  <= ST_FAULT;
            halted_r <= 1'b1;
            fault_r  <= 1'b1;
          end else begin
            pc_r      <= next_pc_s;
            retired_r <= retired_r + 32'd1;
          end
        end
        ST_HALT, ST_FAULT: begin
          state_r <= state_r;
        end
        default: begin
          // Unreachable encoding: stop the core rather than run on.
          state_r  <= ST_FAULT;
          halted_r <= 1'b1;
          fault_r  <= 1'b1;
        end
      endcase
    end
  end

  assign pc      = pc_r;
  assign retired = retired_r;
  assign halted  = halted_r;
  assign fault   = fault_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations, then randomized instruction streams against a reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] pc;
  logic        link_we;
  logic [4:0]  link_reg;
  logic [31:0] link_data;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .pc(pc), .link_we(link_we),
    .link_reg(link_reg), .link_data(link_data), .halted(halted),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: mode 0 = running, 1 = halted by BREAK, 2 = faulted.
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  int          m_mode;

  // Link outputs captured in the last step, for literal checks afterwards.
  logic        s_we;
  logic [4:0]  s_reg;
  logic [31:0] s_data;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] BRK = 32'h0000_000D;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What an instruction does, from the ISA rules: next address, link, break.
  function automatic void model_decode(input logic [31:0] ins, input logic [31:0] rs,
                                       input logic [31:0] rt, input logic [31:0] cur,
                                       output logic [31:0] nxt, output bit lnk,
                                       output logic [4:0] lreg, output bit brk);
    logic [31:0] seq, off, br, jt;
    int srs;
    seq = cur + 32'd4;
    off = {{16{ins[15]}}, ins[15:0]};
    br  = seq + off * 32'd4;
    jt  = {seq[31:28], ins[25:0], 2'b00};
    srs = rs;
    nxt = seq; lnk = 0; lreg = 5'd31; brk = 0;
    case (ins[31:26])
      6'd4: if (rs == rt) nxt = br;
      6'd5: if (rs != rt) nxt = br;
      6'd6: if (srs <= 0) nxt = br;
      6'd7: if (srs > 0) nxt = br;
      6'd1: case (ins[20:16])
              5'd0:  if (srs < 0) nxt = br;
              5'd1:  if (srs >= 0) nxt = br;
              5'd16: begin lnk = 1; if (srs < 0) nxt = br; end
              5'd17: begin lnk = 1; if (srs >= 0) nxt = br; end
              default: ;
            endcase
      6'd2: nxt = jt;
      6'd3: begin nxt = jt; lnk = 1; end
      6'd0: case (ins[5:0])
              6'd8:  nxt = rs;
              6'd9:  begin nxt = rs; lnk = 1; lreg = ins[15:11]; end
              6'd13: brk = 1;
              default: ;
            endcase
      default: ;
    endcase
  endfunction

  // One cycle: drive at negedge, compare everything, advance the model at posedge.
  task automatic step(input logic rst, input logic stl, input logic [31:0] ins,
                      input logic [31:0] rs, input logic [31:0] rt);
    logic [31:0] nxt;
    logic [4:0]  lreg;
    bit lnk, brk, exp_we;
    @(negedge clk);
    reset_n = rst; stall = stl; instr = ins; rs_data = rs; rt_data = rt;
    #1;
    model_decode(ins, rs, rt, m_pc, nxt, lnk, lreg, brk);
    exp_we = rst && m_mode == 0 && !stl && lnk && !brk && nxt[1:0] == 2'b00;
    chk("pc", pc, m_pc);
    chk("retired", retired, m_ret);
    chk("halted", 32'(halted), 32'(m_mode != 0));
    chk("fault", 32'(fault), 32'(m_mode == 2));
    chk("link_we", 32'(link_we), 32'(exp_we));
    chk("link_reg", 32'(link_reg), 32'(lreg));
    chk("link_data", link_data, m_pc + 32'd4);
    s_we = link_we; s_reg = link_reg; s_data = link_data;
    @(posedge clk);
    if (!rst) begin
      m_pc = 32'd0; m_ret = 32'd0; m_mode = 0;
    end else if (m_mode == 0 && !stl) begin
      if (brk) m_mode = 1;
      else if (nxt[1:0] != 2'b00) m_mode = 2;
      else begin m_pc = nxt; m_ret = m_ret + 32'd1; end
    end
    #1;
  endtask

  function automatic logic [31:0] beq(input logic [15:0] imm);
    return {6'b000100, 10'd0, imm};
  endfunction
  function automatic logic [31:0] jmp(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  initial begin
    logic [31:0] w, ins, rs, rt;
    logic rst, stl;
    int kind;
    reset_n = 1'b0; stall = 1'b0; instr = NOP; rs_data = 32'd0; rt_data = 32'd0;
    m_pc = 32'd0; m_ret = 32'd0; m_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_retired", retired, 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_link_we", 32'(link_we), 32'h0);

    // Straight-line code.
    repeat (4) step(1'b1, 1'b0, NOP, 32'd0, 32'd0);
    chk("seq_pc", pc, 32'd16);
    chk("seq_retired", retired, 32'd4);

    // BEQ taken and not taken from pc = 8.
    step(1'b0, 1'b0, NOP, 32'd0, 32'd0);
    repeat (2) step(1'b1, 1'b0, NOP, 32'd0, 32'd0);
    step(1'b1, 1'b0, beq(16'd3), 32'd5, 32'd5);
    chk("beq_taken_we", 32'(s_we), 32'd0);
    chk("beq_taken_pc", pc, 32'd24);
    step(1'b0, 1'b0, NOP, 32'd0, 32'd0);
    repeat (2) step(1'b1, 1'b0, NOP, 32'd0, 32'd0);
    step(1'b1, 1'b0, beq(16'd3), 32'd5, 32'd6);
    chk("beq_not_pc", pc, 32'd12);

    // BGEZAL not taken still links.
    step(1'b0, 1'b0, NOP, 32'd0, 32'd0);
    step(1'b1, 1'b0, jmp(6'b000010, 26'h8), 32'd0, 32'd0);
    chk("j_pc", pc, 32'h20);
    step(1'b1, 1'b0, {6'b000001, 5'd0, 5'b10001, 16'h0010}, 32'hFFFF_FFFF, 32'd0);
    chk("bgezal_we", 32'(s_we), 32'd1);
    chk("bgezal_reg", 32'(s_reg), 32'd31);
    chk("bgezal_data", s_data, 32'h24);
    chk("bgezal_pc", pc, 32'h24);

    // JALR links rd, then JR to a misaligned target faults.
    step(1'b0, 1'b0, NOP, 32'd0, 32'd0);
    step(1'b1, 1'b0, jmp(6'b000010, 26'h10), 32'd0, 32'd0);
    step(1'b1, 1'b0, {16'd0, 5'd9, 5'd0, 6'b001001}, 32'h100, 32'd0);
    chk("jalr_we", 32'(s_we), 32'd1);
    chk("jalr_reg", 32'(s_reg), 32'd9);
    chk("jalr_data", s_data, 32'h44);
    chk("jalr_pc", pc, 32'h100);
    step(1'b1, 1'b0, {26'd0, 6'b001000}, 32'h102, 32'd0);
    chk("jr_mis_we", 32'(s_we), 32'd0);
    chk("jr_mis_fault", 32'(fault), 32'd1);
    chk("jr_mis_halted", 32'(halted), 32'd1);
    chk("jr_mis_pc", pc, 32'h100);
    chk("jr_mis_retired", retired, 32'd2);

    // BREAK halts; reset recovers.
    step(1'b0, 1'b0, NOP, 32'd0, 32'd0);
    step(1'b1, 1'b0, jmp(6'b000010, 26'h4), 32'd0, 32'd0);
    step(1'b1, 1'b0, BRK, 32'd0, 32'd0);
    chk("brk_halted", 32'(halted), 32'd1);
    chk("brk_fault", 32'(fault), 32'd0);
    chk("brk_pc", pc, 32'h10);
    step(1'b1, 1'b0, NOP, 32'd0, 32'd0);
    chk("brk_retired", retired, 32'd1);
    step(1'b0, 1'b0, NOP, 32'd0, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retired", retired, 32'd0);

    // JAL held by stall for three cycles, then released.
    repeat (3) begin
      step(1'b1, 1'b1, jmp(6'b000011, 26'h40), 32'd0, 32'd0);
      chk("stall_we", 32'(s_we), 32'd0);
      chk("stall_pc", pc, 32'd0);
      chk("stall_retired", retired, 32'd0);
    end
    step(1'b1, 1'b0, jmp(6'b000011, 26'h40), 32'd0, 32'd0);
    chk("jal_we", 32'(s_we), 32'd1);
    chk("jal_data", s_data, 32'd4);
    chk("jal_pc", pc, 32'h100);
    chk("jal_retired", retired, 32'd1);

    // Randomized instruction stream.
    for (int n = 0; n < 1500; n++) begin
      w    = $urandom;
      rst  = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if (m_mode != 0 && $urandom_range(0, 5) == 0) rst = 1'b0;
      stl  = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0: rs = 32'd0;
        1: rs = $urandom;
        2: rs = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rs = 32'($urandom_range(1, 4));
      endcase
      rt   = ($urandom_range(0, 1) == 0) ? rs : $urandom;
      kind = $urandom_range(0, 12);
      case (kind)
        0: ins = {6'b100011, w[25:0]};
        1: ins = {6'b000100, w[25:0]};
        2: ins = {6'b000101, w[25:0]};
        3: ins = {6'b000110, w[25:0]};
        4: ins = {6'b000111, w[25:0]};
        5: begin
          ins = {6'b000001, w[25:0]};
          case (w[31:30])
            2'd0: ins[20:16] = 5'd0;
            2'd1: ins[20:16] = 5'd1;
            2'd2: ins[20:16] = 5'd16;
            default: ins[20:16] = 5'd17;
          endcase
        end
        6: ins = {6'b000010, w[25:0]};
        7: ins = {6'b000011, w[25:0]};
        8, 9: begin
          ins = {6'b000000, w[25:6], (kind == 8) ? 6'b001000 : 6'b001001};
          rs  = $urandom & 32'hFFFF_FFFC;
          if ($urandom_range(0, 7) == 0) rs[1:0] = 2'($urandom_range(1, 3));
        end
        10: ins = ($urandom_range(0, 3) == 0) ? BRK : NOP;
        11: ins = {6'b000000, w[25:0]};
        default: ins = w;
      endcase
      step(rst, stl, ins, rs, rt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and control-flow stage of the single-cycle MIPS core, directly upstream of instruction memory and the register file's link-write path. It holds the PC, computes the next PC for sequential, branch, jump and jump-register flow, and generates the link-register write for the and-link instructions. It also counts retired instructions and owns the core's RUN/HALT/FAULT state.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (first imem word)
- clk  input  1  core clock; all state updates on posedge
- reset_n  input  1  synchronous, active-low reset
- stall  input  1  hold PC, suppress link write and retire count this cycle
- instr  input  32  instruction currently fetched at pc
- rs_data  input  32  register file read port A (value of instr[25:21])
- rt_data  input  32  register file read port B (value of instr[20:16])
- pc  output  32  current PC to instruction memory
- link_we  output  1  link write enable to register file (combinational)
- link_reg  output  5  link destination register
- link_data  output  32  value to link (pc+4)
- halted  output  1  core stopped (HALT or FAULT)
- fault  output  1  stopped because of misaligned control-flow target
- retired  output  32  count of instructions retired since reset

## Operation
- pc4 = pc + 4 (mod 2^32). No delay slots: a taken transfer's target is the next fetched address.
- br_tgt = pc4 + (sign_extend(instr[15:0]) << 2), wraps mod 2^32.
- j_tgt = {pc4[31:28], instr[25:0], 2'b00}.
- Decode by op = instr[31:26], funct = instr[5:0], rt field = instr[20:16]:
  - op 000100 BEQ: taken if rs_data == rt_data.
  - op 000101 BNE: taken if rs_data != rt_data.
  - op 000110 BLEZ: taken if rs_data signed <= 0. op 000111 BGTZ: taken if > 0.
  - op 000001 REGIMM: rt 00000 BLTZ, 00001 BGEZ, 10000 BLTZAL, 10001 BGEZAL. Taken conditions are rs signed < 0 and >= 0. The AL forms link to $31 whether or not the branch is taken.
  - op 000010 J -> j_tgt. op 000011 JAL -> j_tgt, link $31.
  - op 000000 funct 001000 JR -> rs_data. funct 001001 JALR -> rs_data, link to rd = instr[15:11].
  - op 000000 funct 001101 BREAK -> enter HALT.
  - Anything else: sequential (pc4).
- link_data = pc4 always; link_reg = 31, or rd for JALR.
- link_we = 1 only for a linking instruction in RUN with stall = 0. JALR with rd = 0 still asserts link_we; the register file discards writes to $0.
- State machine, reset -> RUN:
  - RUN: PC updates to the next PC. BREAK -> HALT. Next PC with bits [1:0] != 0 (only possible via JR/JALR) -> FAULT.
  - HALT and FAULT: terminal until reset. PC frozen, link_we = 0, retired frozen.
- On the BREAK or faulting cycle: PC does not advance, link_we = 0 (JALR to a misaligned target does not link), retired does not increment.
- retired increments by 1 on each RUN cycle with stall = 0 that does not transition to HALT or FAULT. It wraps at 2^32.

## Timing
- Reset values (edge with reset_n = 0): pc = RESET_PC, state RUN, halted = 0, fault = 0, retired = 0. link_we is 0 while reset_n = 0.
- Reset asserted mid-operation, including in HALT or FAULT, overrides everything on that edge. The first instruction after release is fetched at RESET_PC.
- pc, halted, fault and retired are registered; each changes one posedge after the deciding instruction.
- link_we, link_reg and link_data are combinational from instr, rs_data and pc. They are valid in the same cycle and consumed by the register file on the same posedge.
- stall = 1: pc, state and retired hold; link_we = 0. stall is ignored in HALT and FAULT.
- stall together with BREAK or a misaligned target: no transition until stall drops.
- Zero-latency control flow: the instruction at the target executes in the cycle immediately after the branch.

## Test plan
- Sequential run: RESET_PC = 0 and 4 non-branch words. After 4 edges pc = 16, retired = 4.
- BEQ taken, rs = rt = 5, imm = 3, pc = 8: next pc = 24, link_we = 0. With rt = 6, next pc = 12.
- BGEZAL not taken, rs = 32'hFFFF_FFFF, pc = 0x20: next pc = 0x24, link_we = 1, link_reg = 31, link_data = 0x24.
- JALR rd = 9, rs = 0x100, pc = 0x40: link $9 = 0x44, next pc = 0x100. JR with rs = 0x102: fault = 1, halted = 1, pc stays, link_we = 0.
- BREAK at pc = 0x10: halted = 1, pc stays 0x10, retired frozen. A later reset_n = 0 edge gives pc = 0, halted = 0, retired = 0.
- stall held 3 cycles on a JAL: pc, retired unchanged and link_we = 0 throughout. On release, a single link write of pc+4 and the jump are taken.
